dec_scan_seq: RTL and testbench
===============================

Name: dec_scan_seq

Overview:
- Parametrised N-to-2^N one-hot decoder with registered outputs and a built-in scan sequencer.
- Direct mode: decodes an external select on every clock.
- Scan mode: an internal index steps through all 2^N lines, holding each line for DWELL cycles, with load, hold and wrap signalling.
- Drives row/line strobes for multiplexed displays, keypad scanning and bank selection. Replaces the fixed 2-to-4 and 3-to-8 gate-level decoders where timing or sequencing is needed.

Parameters:
- N, 3: select width; output width is 2^N; legal range 1..6.
- DWELL, 4: cycles each line stays active in scan mode; legal range >= 1.
- ACTIVE_LOW, 0: 0 = active line is 1 and others are 0; 1 = all outputs inverted.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: output enable; when low, all lines are inactive.
- mode, input, 1: 0 = direct decode of d; 1 = scan sequencer.
- d, input, N: direct-mode select; load value in scan mode.
- load, input, 1: scan mode only; loads d into the index and restarts the dwell count.
- hold, input, 1: scan mode only; freezes the index and the dwell counter.
- y, output, 2^N: registered one-hot line outputs, with polarity set by ACTIVE_LOW.
- idx, output, N: registered current index; y always corresponds to idx.
- wrap, output, 1: one-cycle pulse, registered, asserted in the cycle idx becomes 0 by scan advance.
- busy, output, 1: registered; high while en=1 and mode=1.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Reset values:
  - idx = 0, dwell counter = 0, wrap = 0, busy = 0.
  - y = all inactive: 0 for ACTIVE_LOW=0, all ones for ACTIVE_LOW=1.
- Registers: y, idx, wrap and busy are all registered. y is computed from next-state idx and en, so y = onehot(idx) in the same cycle idx updates. No combinational input-to-output path.
- Dwell counter: width max(1, clog2(DWELL)); counts 0..DWELL-1.
- Per-edge priority: rst > en=0 > mode=0 (direct) > load > hold > scan advance.
- en=0:
  - Next y is all inactive and the dwell counter clears to 0.
  - idx holds its value; wrap = 0; busy = 0.
- Direct mode (en=1, mode=0):
  - idx <= d; y <= onehot(d); latency 1 clock.
  - load, hold and the dwell counter are ignored; dwell counter is held at 0; wrap = 0.
- Scan mode (en=1, mode=1):
  - load=1: idx <= d, dwell <= 0, wrap = 0. load overrides hold.
  - hold=1 (load=0): idx and dwell are frozen, wrap = 0, y unchanged.
  - Otherwise, if dwell < DWELL-1: dwell increments.
  - Otherwise (dwell == DWELL-1): dwell <= 0 and idx <= (idx+1) mod 2^N.
  - wrap = 1 for exactly the cycle in which idx changes from 2^N-1 to 0 by advance. A load of d=0 does not assert wrap.
- DWELL=1: idx advances every cycle with no hold/load active; each line is active for exactly 1 cycle.
- Mode switch 0->1: scan starts from the current idx with dwell = 0, so the first line lasts a full DWELL cycles.
- Mode switch 1->0: direct decode takes effect on the next edge.
- en rising with mode=1: y reappears on the held idx with a fresh dwell of DWELL cycles.
- rst asserted mid-scan: the next edge returns to reset values regardless of all other inputs.
- Invariant: whenever en was high on the previous edge, y has exactly one active line.

Test Plan:
1. Reset, direct decode (N=3, ACTIVE_LOW=0): rst=1 for 2 cycles -> y=8'h00, idx=0. Then en=1, mode=0, d = 0..7 one per cycle -> y one cycle later = 01, 02, 04, ..., 80; idx tracks d.
2. Scan with wrap (DWELL=4): en=1, mode=1 from idx=0 -> each of y=01..80 held 4 cycles. idx 7->0 after 32 cycles with wrap=1 for 1 cycle only; busy=1 throughout.
3. Load/hold priority: mid-scan, load=1 with d=5 and hold=1 -> idx=5, y=8'h20, dwell restarts. Then hold=1 for 10 cycles -> y stays 8'h20. Release -> 4 more cycles of 8'h20, then 8'h40.
4. Enable and reset mid-operation: en=0 during idx=3 -> y=8'h00, idx=3. en=1 -> y=8'h08 for a full 4 cycles. rst=1 at idx=6 -> next cycle y=0, idx=0, wrap=0.
5. Corner parameters: N=1, DWELL=1, ACTIVE_LOW=1 scan -> y alternates 2'b10, 2'b01 every cycle; wrap pulses every second cycle; en=0 -> y=2'b11.
6. Mode switching: direct with d=2, then mode=1 -> y=8'h04 for 4 cycles, then 8'h08. Switch mode=0 with d=7 -> y=8'h80 next cycle.

Source files
------------

// File: rtl/dec_scan_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dec_scan_seq : N-to-2^N registered one-hot decoder with built-in scan sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module dec_scan_seq #(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       d,
  input  logic               load,
  input  logic               hold,
  output logic [(1<<N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               wrap,
  output logic               busy
);

  localparam int            W          = 1 << N;
  localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [W-1:0]  Y_IDLE     = {W{(ACTIVE_LOW != 0)}};

  logic [N-1:0]  idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  y_q, y_d;
  logic          wrap_q, wrap_d;
  logic          busy_q, busy_d;
  logic          en_q;

  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    busy_d  = 1'b0;
    if (!en) begin
      dwell_d = '0;
    end else if (!mode) begin
      idx_d   = d;
      dwell_d = '0;
    end else begin
      busy_d = 1'b1;
      if (load) begin
        idx_d   = d;
        dwell_d = '0;
      end else if (hold) begin
        dwell_d = dwell_q;
      end else if (!en_q) begin
        // Line reappearing after a disable gets a fresh, full dwell.
        dwell_d = '0;
      end else if (dwell_q != DWELL_LAST) begin
        dwell_d = dwell_q + DW'(1);
      end else begin
        dwell_d = '0;
        idx_d   = idx_q + N'(1);
        wrap_d  = (idx_q == {N{1'b1}});
      end
    end
    y_d = en ? ((W'(1) << idx_d) ^ Y_IDLE) : Y_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      dwell_q <= '0;
      y_q     <= Y_IDLE;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      en_q    <= en;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dec_scan_seq : directed self-checking bench, N=3/DWELL=4 and N=1/DWELL=1/active-low
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dec_scan_seq;

  logic       clk = 1'b0;
  logic       rst, en, mode, load, hold;
  logic [2:0] d;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap, busy;

  logic       c_rst, c_en, c_mode, c_load, c_hold;
  logic [0:0] c_d;
  logic [1:0] c_y;
  logic [0:0] c_idx;
  logic       c_wrap, c_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dec_scan_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .load(load), .hold(hold),
    .y(y), .idx(idx), .wrap(wrap), .busy(busy)
  );

  dec_scan_seq #(.N(1), .DWELL(1), .ACTIVE_LOW(1)) u_dut_c (
    .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode), .d(c_d), .load(c_load), .hold(c_hold),
    .y(c_y), .idx(c_idx), .wrap(c_wrap), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; hold = 1'b0; d = 3'd0;
    c_rst = 1'b1; c_en = 1'b0; c_mode = 1'b0; c_load = 1'b0; c_hold = 1'b0; c_d = 1'b0;

    // 1: reset, then direct decode of every select value
    step(); step();
    chk("rst_y", y, 8'h00);
    chk("rst_idx", idx, 3'd0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 3'(i);
      step();
      chk("dir_y", y, 32'h1 << i);
      chk("dir_idx", idx, i);
      chk("dir_busy", busy, 1'b0);
    end

    // 2: full scan from idx 0, wrap after 32 cycles
    d = 3'd0;
    step();
    mode = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("scan_idx", idx, (k / 4) % 8);
      chk("scan_y", y, 32'h1 << ((k / 4) % 8));
      chk("scan_wrap", wrap, (k == 32) ? 1 : 0);
      chk("scan_busy", busy, 1'b1);
    end

    // 3: load beats hold, hold freezes, release resumes with full dwell
    step(); step();
    load = 1'b1; hold = 1'b1; d = 3'd5;
    step();
    chk("load_idx", idx, 3'd5);
    chk("load_y", y, 8'h20);
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_y", y, 8'h20);
      chk("hold_wrap", wrap, 1'b0);
    end
    hold = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("rel_y", y, (j < 4) ? 8'h20 : 8'h40);
    end

    // 4: disable at idx 3, re-enable with fresh dwell, reset at idx 6
    load = 1'b1; d = 3'd3;
    step();
    load = 1'b0; en = 1'b0;
    step();
    chk("dis_y", y, 8'h00);
    chk("dis_idx", idx, 3'd3);
    chk("dis_busy", busy, 1'b0);
    en = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      step();
      chk("ren_idx", idx, 3 + (j - 1) / 4);
      chk("ren_y", y, 32'h1 << (3 + (j - 1) / 4));
    end
    rst = 1'b1;
    step();
    chk("mrst_y", y, 8'h00);
    chk("mrst_idx", idx, 3'd0);
    chk("mrst_wrap", wrap, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    rst = 1'b0;

    // 6: mode switching direct -> scan -> direct, then load of 0 without wrap
    mode = 1'b0; d = 3'd2;
    step();
    chk("ms_dir_y", y, 8'h04);
    mode = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("ms_scan_y", y, (j < 4) ? 8'h04 : 8'h08);
    end
    mode = 1'b0; d = 3'd7;
    step();
    chk("ms_back_y", y, 8'h80);
    chk("ms_back_busy", busy, 1'b0);
    mode = 1'b1; load = 1'b1; d = 3'd0;
    step();
    chk("ld0_idx", idx, 3'd0);
    chk("ld0_wrap", wrap, 1'b0);
    load = 1'b0;

    // 5: N=1, DWELL=1, active-low scan
    step();
    chk("c_rst_y", c_y, 2'b11);
    chk("c_rst_idx", c_idx, 1'b0);
    c_rst = 1'b0; c_en = 1'b1; c_mode = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("c_idx", c_idx, (k - 1) % 2);
      chk("c_y", c_y, ((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
      chk("c_wrap", c_wrap, (k >= 3 && (k - 1) % 2 == 0) ? 1 : 0);
    end
    c_en = 1'b0;
    step();
    chk("c_dis_y", c_y, 2'b11);
    chk("c_dis_wrap", c_wrap, 1'b0);
    chk("c_dis_busy", c_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
